// File: rtl/toi2s_pkg.sv
// Shared types and constants for the amp_cfg boot loader (amp_boot_loader).
// AMP_BOOT_RETRY_EN selects the automatic NACK-retry behaviour.
package toi2s_pkg;

    localparam int unsigned AMP_ST_BUSY    = 0;
    localparam int unsigned AMP_ST_DONE    = 1;
    localparam int unsigned AMP_ST_NACK    = 2;
    localparam int unsigned AMP_ST_IDX_LSB = 3;
    localparam int unsigned AMP_ST_RETRY   = 7;

    localparam int unsigned AMP_RETRY_MAX  = 3;

    // RETRY is only ever entered when AMP_BOOT_RETRY_EN is defined.
    typedef enum logic [2:0] {IDLE, START, BYTE, ACK, STOP, RETRY} amp_i2c_state_t;

    // Byte 0 is the write address; bytes 1..8 come from the snapshot, lowest first.
    function automatic logic [7:0] amp_sel_byte(input logic [63:0] snap,
                                                input logic [3:0]  idx,
                                                input logic [6:0]  addr);
        logic [3:0] k;
        if (idx == 4'd0) begin
            return {addr, 1'b0};
        end
        k = idx - 4'd1;
        return 8'(snap >> ({3'b000, k} << 3));
    endfunction

endpackage

// File: rtl/amp_boot_loader_phase_gen.sv
// Quarter-period generator for the amp I2C master: one q_tick every CLK_DIV clocks
// while enabled, plus a 2-bit quarter index; both restart from zero when disabled.
module amp_i2c_phase_gen #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       en_i,
    output logic       q_tick_o,
    output logic [1:0] quarter_o
);

    localparam logic [7:0] CntMax = 8'(CLK_DIV - 1);

    logic [7:0] cnt_q, cnt_d;
    logic [1:0] qtr_q, qtr_d;

    always_comb begin
        q_tick_o = en_i && (cnt_q == CntMax);
        cnt_d    = 8'd0;
        qtr_d    = 2'd0;
        if (en_i) begin
            cnt_d = q_tick_o ? 8'd0 : cnt_q + 8'd1;
            qtr_d = q_tick_o ? qtr_q + 2'd1 : qtr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 8'd0;
            qtr_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            qtr_q <= qtr_d;
        end
    end

    assign quarter_o = qtr_q;

endmodule

// File: rtl/amp_boot_loader.sv
// Write-only I2C master that pushes the bootmem0..7 snapshot to the amplifier on an
// amp_init rising edge. Optional macro AMP_BOOT_RETRY_EN enables up to 3 NACK retries.
module amp_boot_loader
    import toi2s_pkg::*;
#(
    parameter int unsigned CLK_DIV   = 4,
    parameter logic [6:0]  DEV_ADDR  = 7'h2C,
    parameter int unsigned NUM_BYTES = 8
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        amp_init,
    input  logic [63:0] bootmem,
    output logic [7:0]  status,
    output logic        busy,
    output logic        done_pulse,
    output logic        scl_oe,
    output logic        sda_oe,
    input  logic        sda_i
);

    amp_i2c_state_t state_q, state_d;

    logic        init_q;
    logic [63:0] snap_q, snap_d;
    logic [2:0]  bit_q, bit_d;
    logic [3:0]  byte_q, byte_d;
    logic        nack_smp_q, nack_smp_d;
    logic        fail_q, fail_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        nack_q, nack_d;
    logic [3:0]  idx_q, idx_d;
    logic        pulse_q, pulse_d;
    logic        retried;

    logic        q_tick;
    logic [1:0]  quarter;
    logic        last_q;
    logic        init_rise;
    logic [7:0]  cur_byte;

    amp_i2c_phase_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_phase_gen (
        .clk_i     (clk),
        .rst_ni    (resetb),
        .en_i      (state_q != IDLE),
        .q_tick_o  (q_tick),
        .quarter_o (quarter)
    );

    assign init_rise = amp_init && !init_q;
    assign last_q    = q_tick && (quarter == 2'd3);
    assign cur_byte  = amp_sel_byte(snap_q, byte_q, DEV_ADDR);

`ifdef AMP_BOOT_RETRY_EN
    logic [1:0] retry_cnt_q, retry_cnt_d;
    logic [3:0] wait_q, wait_d;
    logic       retried_q, retried_d;
    assign retried = retried_q;
`else
    assign retried = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        bit_d      = bit_q;
        byte_d     = byte_q;
        nack_smp_d = nack_smp_q;
        fail_d     = fail_q;
        busy_d     = busy_q;
        done_d     = done_q;
        nack_d     = nack_q;
        idx_d      = idx_q;
        pulse_d    = 1'b0;
`ifdef AMP_BOOT_RETRY_EN
        retry_cnt_d = retry_cnt_q;
        wait_d      = wait_q;
        retried_d   = retried_q;
`endif
        case (state_q)
            IDLE: begin
                if (init_rise) begin
                    state_d = START;
                    snap_d  = bootmem;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    nack_d  = 1'b0;
                    idx_d   = 4'd0;
                    fail_d  = 1'b0;
`ifdef AMP_BOOT_RETRY_EN
                    retry_cnt_d = 2'd0;
                    retried_d   = 1'b0;
`endif
                end
            end
            START: begin
                if (last_q) begin
                    state_d = BYTE;
                    bit_d   = 3'd7;
                    byte_d  = 4'd0;
                end
            end
            BYTE: begin
                if (last_q) begin
                    if (bit_q == 3'd0) begin
                        state_d = ACK;
                    end else begin
                        bit_d = bit_q - 3'd1;
                    end
                end
            end
            ACK: begin
                if (q_tick && quarter == 2'd2) begin
                    nack_smp_d = sda_i;
                end
                if (last_q) begin
                    if (nack_smp_q) begin
                        state_d = STOP;
                        fail_d  = 1'b1;
                    end else if (byte_q == 4'(NUM_BYTES)) begin
                        state_d = STOP;
                    end else begin
                        state_d = BYTE;
                        byte_d  = byte_q + 4'd1;
                        bit_d   = 3'd7;
                    end
                end
            end
            STOP: begin
                if (last_q) begin
`ifdef AMP_BOOT_RETRY_EN
                    if (fail_q && retry_cnt_q != 2'(AMP_RETRY_MAX)) begin
                        state_d   = RETRY;
                        wait_d    = 4'd0;
                        retried_d = 1'b1;
                    end else
`endif
                    begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pulse_d = 1'b1;
                        nack_d  = fail_q;
                        idx_d   = fail_q ? byte_q : 4'd0;
                    end
                end
            end
`ifdef AMP_BOOT_RETRY_EN
            RETRY: begin
                // Bus stays released for 16 quarters before the frame restarts.
                if (q_tick) begin
                    if (wait_q == 4'd15) begin
                        state_d     = START;
                        fail_d      = 1'b0;
                        retry_cnt_d = retry_cnt_q + 2'd1;
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            state_q    <= IDLE;
            init_q     <= 1'b0;
            snap_q     <= 64'd0;
            bit_q      <= 3'd0;
            byte_q     <= 4'd0;
            nack_smp_q <= 1'b0;
            fail_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_q     <= 1'b0;
            idx_q      <= 4'd0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_q     <= amp_init;
            snap_q     <= snap_d;
            bit_q      <= bit_d;
            byte_q     <= byte_d;
            nack_smp_q <= nack_smp_d;
            fail_q     <= fail_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_q     <= nack_d;
            idx_q      <= idx_d;
            pulse_q    <= pulse_d;
        end
    end

`ifdef AMP_BOOT_RETRY_EN
    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            retry_cnt_q <= 2'd0;
            wait_q      <= 4'd0;
            retried_q   <= 1'b0;
        end else begin
            retry_cnt_q <= retry_cnt_d;
            wait_q      <= wait_d;
            retried_q   <= retried_d;
        end
    end
`endif

    // Pad drive decoded from registered state; 1 pulls the line low.
    always_comb begin
        scl_oe = 1'b0;
        sda_oe = 1'b0;
        case (state_q)
            START: sda_oe = quarter[1];
            BYTE: begin
                scl_oe = !quarter[1];
                sda_oe = !cur_byte[bit_q];
            end
            ACK:  scl_oe = !quarter[1];
            STOP: begin
                scl_oe = (quarter == 2'd0);
                sda_oe = !quarter[1];
            end
            default: ;
        endcase
    end

    always_comb begin
        status                          = 8'd0;
        status[AMP_ST_BUSY]             = busy_q;
        status[AMP_ST_DONE]             = done_q;
        status[AMP_ST_NACK]             = nack_q;
        status[AMP_ST_IDX_LSB +: 4]     = idx_q;
        status[AMP_ST_RETRY]            = retried;
    end

    assign busy       = busy_q;
    assign done_pulse = pulse_q;

endmodule
